// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg
// Shared types and constants for the two-requester ALU arbiter.
//   state_t     : FSM state encoding (IDLE, EXEC, RESP)
//   ALU_*       : the 16 control codes understood by the shared ALU.
//                 Codes 0-9 produce a result word; 10-15 produce a compare flag.
//   CNT_W       : width of the EXEC wait counter (covers WAIT_CYC 0..15)
package alu_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int unsigned CNT_W = 4;

  // Result ops
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  // Compare ops
  localparam logic [3:0] ALU_EQ   = 4'd10;
  localparam logic [3:0] ALU_NE   = 4'd11;
  localparam logic [3:0] ALU_LT   = 4'd12;
  localparam logic [3:0] ALU_GE   = 4'd13;
  localparam logic [3:0] ALU_LTU  = 4'd14;
  localparam logic [3:0] ALU_GEU  = 4'd15;

endpackage

// File: rtl/alu_arb_if.sv
// alu_arb_if
// One requester channel of the ALU arbiter: an operation request and the
// matching response.
//   req_valid/req_ready : request handshake; req_op/req_a/req_b payload
//   rsp_valid/rsp_ready : response handshake; rsp_res/rsp_c payload
// Handshake rule (both directions): a transfer happens on a rising clock edge
// where valid and ready are both 1. The source keeps valid and payload stable
// until that edge; ready may depend combinationally on valid. A request source
// may drop req_valid without a transfer.
// Modports: master = requester side, slave = arbiter side.
interface alu_arb_if;

  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_res;
  logic        rsp_c;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_res, rsp_c
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_res, rsp_c
  );

endinterface

// File: rtl/alu_arb_rr_arb2.sv
// rr_arb2
// Two-way round-robin arbiter.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : arbitration allowed this cycle
//   valid[1:0] : request vector
//   grant[1:0] : one-hot grant (combinational), zero when en is low
//   ptr        : requester that wins when both are valid
// After every grant the pointer moves to the requester that did not win.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant,
  output logic       ptr
);

  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  // Granting requester 0 points at 1 and vice versa, so the new pointer is
  // simply grant[0].
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (grant != 2'b00) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/alu_arb.sv
// alu_arb
// Shares one combinational ALU between two requesters. One operation is in
// flight at a time: accept (IDLE) -> hold operands on the ALU (EXEC) ->
// present the captured result until consumed (RESP).
//   clk, rst_n        : clock, synchronous active-low reset
//   ch0, ch1          : requester channels (alu_arb_if.slave)
//   alu_upr/a/b       : control code and operands driven to the ALU
//   alu_out, alu_c    : ALU result word and compare flag
//   dbg_state/ptr/cnt : FSM state, round-robin pointer, wait counter
// WAIT_CYC (0..15) adds cycles of operand hold before the result is captured.
module alu_arb
  import alu_arb_pkg::*;
#(
  parameter int WAIT_CYC = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_arb_if.slave         ch0,
  alu_arb_if.slave         ch1,
  output logic [3:0]       alu_upr,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  input  logic [31:0]      alu_out,
  input  logic             alu_c,
  output state_t           dbg_state,
  output logic             dbg_ptr,
  output logic [CNT_W-1:0] dbg_cnt
);

  localparam logic [CNT_W-1:0] WAIT_LIM = WAIT_CYC[CNT_W-1:0];

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             gnt_id;
  logic [1:0]       rsp_valid_q;
  logic [1:0][31:0] rsp_res_q;
  logic [1:0]       rsp_c_q;

  logic             arb_en;
  logic [1:0]       grant;
  logic             ptr;
  logic             rsp_ready_g;

  // Reset is folded into the enable so no ready is raised while rst_n is low.
  assign arb_en = rst_n && (state == ST_IDLE);

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (arb_en),
    .valid ({ch1.req_valid, ch0.req_valid}),
    .grant (grant),
    .ptr   (ptr)
  );

  assign rsp_ready_g = gnt_id ? ch1.rsp_ready : ch0.rsp_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      gnt_id      <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_res_q   <= '0;
      rsp_c_q     <= 2'b00;
      alu_upr     <= 4'd0;
      alu_a       <= 32'd0;
      alu_b       <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant != 2'b00) begin
            gnt_id  <= grant[1];
            alu_upr <= grant[1] ? ch1.req_op : ch0.req_op;
            alu_a   <= grant[1] ? ch1.req_a  : ch0.req_a;
            alu_b   <= grant[1] ? ch1.req_b  : ch0.req_b;
            cnt     <= '0;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // Operands have been on the ALU for cnt+1 cycles; capture once
          // that reaches 1+WAIT_CYC.
          if (cnt == WAIT_LIM) begin
            rsp_res_q[gnt_id]   <= alu_out;
            rsp_c_q[gnt_id]     <= alu_c;
            rsp_valid_q[gnt_id] <= 1'b1;
            cnt                 <= '0;
            state               <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_valid_q[gnt_id] && rsp_ready_g) begin
            rsp_valid_q <= 2'b00;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ch0.req_ready = grant[0];
  assign ch1.req_ready = grant[1];
  assign ch0.rsp_valid = rsp_valid_q[0];
  assign ch1.rsp_valid = rsp_valid_q[1];
  assign ch0.rsp_res   = rsp_res_q[0];
  assign ch1.rsp_res   = rsp_res_q[1];
  assign ch0.rsp_c     = rsp_c_q[0];
  assign ch1.rsp_c     = rsp_c_q[1];

  assign dbg_state = state;
  assign dbg_ptr   = ptr;
  assign dbg_cnt   = cnt;

endmodule
